ni_packetizer: RTL and testbench

//  Network-interface injection stage for one torus node: accepts packet commands plus payload

---
 rtl/ni_packetizer_pkg.sv | 28 ++
 rtl/ni_packetizer_sync_fifo.sv | 65 ++++++
 rtl/ni_packetizer.sv | 147 ++++++++++++++
 tb/tb_ni_packetizer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ni_packetizer_pkg.sv
// Shared definitions for the NI packetizer: flit width, header layout and FSM states.
// Imported by the packetizer top and its payload FIFO.
package ni_packetizer_pkg;

  localparam int FLIT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_e;

  // Header flit layout, MSB first: {dst_x, dst_y, len}
  typedef struct packed {
    logic [1:0] dst_x;
    logic [1:0] dst_y;
    logic [3:0] len;
  } header_t;

  function automatic logic [FLIT_W-1:0] make_header(input logic [3:0] dst, input logic [3:0] len);
    header_t h;
    h.dst_x = dst[3:2];
    h.dst_y = dst[1:0];
    h.len   = len;
    return h;
  endfunction

endpackage

// File: rtl/ni_packetizer_sync_fifo.sv
// Single-clock payload FIFO with show-ahead read data; pointers wrap modulo DEPTH and
// the occupancy counter carries one extra bit so full and empty are unambiguous.
module ni_packetizer_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == COUNT_FULL);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define validity,
  // and leaving the array reset-free lets it map onto plain RAM/register cells.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ni_packetizer.sv
// Network-interface injection stage: frames local-core commands and payload bytes into
// header + body flits for the router's local input under credit-based flow control.
module ni_packetizer
  import ni_packetizer_pkg::*;
#(
  parameter int NODE_X     = 0,
  parameter int NODE_Y     = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int CREDITS    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_dst,
  input  logic [3:0]        cmd_len,
  input  logic              dat_valid,
  output logic              dat_ready,
  input  logic [FLIT_W-1:0] dat_in,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_wr,
  input  logic              credit_in,
  output logic              busy,
  output logic              err_credit
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

  if (NODE_X < 0 || NODE_X > 3 || NODE_Y < 0 || NODE_Y > 3) begin : g_bad_node
    $error("NODE_X/NODE_Y must lie in 0..3");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (CREDITS < 1) begin : g_bad_credits
    $error("CREDITS must be at least 1");
  end

  state_e            state_q, state_d;
  logic [3:0]        dst_q, dst_d;
  logic [3:0]        rem_q, rem_d;
  logic [FLIT_W-1:0] flit_out_q, flit_out_d;
  logic              flit_wr_q, flit_wr_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic              err_q, err_d;

  logic              fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [FLIT_W-1:0] fifo_dout;
  logic              have_credit;

  // Payload intake runs independently of the FSM; bytes may arrive before their command.
  ni_packetizer_sync_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dat_valid),
    .pop   (fifo_pop),
    .din   (dat_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign have_credit = (credit_q != '0);
  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign dat_ready   = !fifo_full;
  assign flit_out    = flit_out_q;
  assign flit_wr     = flit_wr_q;
  assign err_credit  = err_q;

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    flit_out_d = flit_out_q;
    flit_wr_d  = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          dst_d   = cmd_dst;
          rem_d   = cmd_len;
          state_d = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (have_credit) begin
          flit_out_d = make_header(dst_q, rem_q);
          flit_wr_d  = 1'b1;
          state_d    = (rem_q == 4'd0) ? ST_IDLE : ST_BODY;
        end
      end
      ST_BODY: begin
        if (have_credit && !fifo_empty) begin
          fifo_pop   = 1'b1;
          flit_out_d = fifo_dout;
          flit_wr_d  = 1'b1;
          rem_d      = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A returned credit in the same cycle as a sent flit cancels out.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    case ({flit_wr_d, credit_in})
      2'b10: credit_d = credit_q - CW'(1);
      2'b01: begin
        if (credit_q == CREDIT_MAX) err_d = 1'b1;
        else                        credit_d = credit_q + CW'(1);
      end
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      dst_q      <= '0;
      rem_q      <= '0;
      flit_out_q <= '0;
      flit_wr_q  <= 1'b0;
      credit_q   <= CREDIT_MAX;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      flit_out_q <= flit_out_d;
      flit_wr_q  <= flit_wr_d;
      credit_q   <= credit_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed bench for ni_packetizer: stimulus queues expected flits, a monitor pops and
// compares each flit the DUT writes; status outputs are checked inline.
module tb_ni_packetizer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_dst = '0;
  logic [3:0] cmd_len = '0;
  logic       dat_valid = 1'b0;
  logic       dat_ready;
  logic [7:0] dat_in = '0;
  logic [7:0] flit_out;
  logic       flit_wr;
  logic       credit_in = 1'b0;
  logic       busy;
  logic       err_credit;

  ni_packetizer #(
    .NODE_X     (0),
    .NODE_Y     (0),
    .FIFO_DEPTH (16),
    .CREDITS    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dst    (cmd_dst),
    .cmd_len    (cmd_len),
    .dat_valid  (dat_valid),
    .dat_ready  (dat_ready),
    .dat_in     (dat_in),
    .flit_out   (flit_out),
    .flit_wr    (flit_wr),
    .credit_in  (credit_in),
    .busy       (busy),
    .err_credit (err_credit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] val;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   n_flits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Monitor: outputs are registered, so sample on the falling edge.
  always @(negedge clk) begin
    if (rst && flit_wr) begin
      n_flits++;
      if (exp_q.size() == 0) begin
        fail_now($sformatf("unexpected_flit 0x%0h", flit_out));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("flit_value", {24'd0, flit_out}, {24'd0, e.val});
        if (e.at >= 0) check("flit_cycle", cyc, e.at);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_flit(input logic [7:0] v, input int at = -1);
    exp_t e;
    e.val = v;
    e.at  = at;
    exp_q.push_back(e);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int guard = 0;
    while (!dat_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (!dat_ready) fail_now("push_timeout");
    dat_valid = 1'b1;
    dat_in    = b;
    tick();
    dat_valid = 1'b0;
  endtask

  // Returns t = the clock edge at which the command handshake happened.
  task automatic send_cmd(input logic [3:0] dst, input logic [3:0] len, output int t);
    int guard = 0;
    while (!cmd_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (!cmd_ready) fail_now("cmd_timeout");
    t = cyc + 1;
    expect_flit({dst, len}, t + 1);
    cmd_valid = 1'b1;
    cmd_dst   = dst;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic give_credits(input int n);
    credit_in = 1'b1;
    tick(n);
    credit_in = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || exp_q.size() != 0) && guard < 200) begin
      tick();
      guard++;
    end
    if (busy || exp_q.size() != 0) fail_now("idle_timeout");
  endtask

  task automatic tick_until(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    int t;
    int n0;

    // Reset state
    #22;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_dat_ready", dat_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_flit_wr", flit_wr, 0);
    check("rst_flit_out", flit_out, 0);
    check("rst_err_credit", err_credit, 0);
    tick(2);
    rst = 1'b1;
    tick();

    // Basic packet with exact latency
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    n0 = n_flits;
    send_cmd(4'b1001, 4'd3, t);
    expect_flit(8'hA1, t + 2);
    expect_flit(8'hA2, t + 3);
    expect_flit(8'hA3, t + 4);
    check("t2_cmd_ready_busy", cmd_ready, 0);
    tick_until(t + 2);
    check("t2_busy_mid", busy, 1);
    tick_until(t + 5);
    check("t2_busy_done", busy, 0);
    check("t2_cmd_ready_done", cmd_ready, 1);
    check("t2_flit_count", n_flits - n0, 4);
    give_credits(4);

    // Header-only packet
    n0 = n_flits;
    send_cmd(4'hF, 4'd0, t);
    tick_until(t + 1);
    check("t4_busy", busy, 0);
    check("t4_cmd_ready", cmd_ready, 1);
    tick();
    check("t4_flit_count", n_flits - n0, 1);
    give_credits(1);

    // Credit exhaustion and one-per-cycle recovery
    push_byte(8'hB0);
    push_byte(8'hB1);
    push_byte(8'hB2);
    push_byte(8'hB3);
    push_byte(8'hB4);
    push_byte(8'hB5);
    n0 = n_flits;
    send_cmd(4'h6, 4'd6, t);
    expect_flit(8'hB0, t + 2);
    expect_flit(8'hB1, t + 3);
    expect_flit(8'hB2, t + 4);
    tick_until(t + 8);
    check("t3_stalled_count", n_flits - n0, 4);
    check("t3_busy_stalled", busy, 1);
    expect_flit(8'hB3, t + 10);
    expect_flit(8'hB4, t + 11);
    expect_flit(8'hB5, t + 12);
    give_credits(3);
    tick(3);
    check("t3_total_count", n_flits - n0, 7);
    check("t3_busy_done", busy, 0);
    give_credits(4);

    // Credit overflow: sticky error, counter saturates at 4
    check("t6_err_before", err_credit, 0);
    give_credits(1);
    check("t6_err_set", err_credit, 1);
    tick(3);
    check("t6_err_sticky", err_credit, 1);
    push_byte(8'h11);
    push_byte(8'h12);
    push_byte(8'h13);
    push_byte(8'h14);
    n0 = n_flits;
    send_cmd(4'h3, 4'd4, t);
    expect_flit(8'h11);
    expect_flit(8'h12);
    expect_flit(8'h13);
    expect_flit(8'h14);
    tick_until(t + 8);
    check("t6_saturated_count", n_flits - n0, 4);
    give_credits(1);
    tick(2);
    check("t6_final_count", n_flits - n0, 5);
    check("t6_busy_done", busy, 0);
    give_credits(4);

    // FIFO full, ignored push, simultaneous push+pop at count 15
    credit_in = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'hC0 + 8'(i));
    check("t5_full_ready", dat_ready, 0);
    dat_valid = 1'b1;
    dat_in    = 8'hEE;
    tick(2);
    dat_valid = 1'b0;
    check("t5_full_after_ignored", dat_ready, 0);
    send_cmd(4'h0, 4'd2, t);
    expect_flit(8'hC0, t + 2);
    expect_flit(8'hC1, t + 3);
    dat_valid = 1'b1;
    dat_in    = 8'hD0;
    tick_until(t + 3);
    dat_valid = 1'b0;
    check("t5_count15_ready", dat_ready, 1);
    push_byte(8'hD1);
    check("t5_refull_ready", dat_ready, 0);
    send_cmd(4'h0, 4'd15, t);
    for (int i = 2; i < 16; i++) expect_flit(8'hC0 + 8'(i));
    expect_flit(8'hD0);
    wait_idle();
    check("t5_drained_ready", dat_ready, 1);
    send_cmd(4'h0, 4'd1, t);
    expect_flit(8'hD1);
    wait_idle();
    credit_in = 1'b0;
    tick();

    // Asynchronous reset in the middle of a body
    push_byte(8'hE0);
    push_byte(8'hE1);
    n0 = n_flits;
    send_cmd(4'hA, 4'd5, t);
    expect_flit(8'hE0);
    expect_flit(8'hE1);
    tick_until(t + 6);
    check("t1_busy_before", busy, 1);
    check("t1_count_before", n_flits - n0, 3);
    #3;
    rst = 1'b0;
    #1;
    check("t1_flit_wr", flit_wr, 0);
    check("t1_busy", busy, 0);
    check("t1_cmd_ready", cmd_ready, 1);
    check("t1_dat_ready", dat_ready, 1);
    check("t1_flit_out", flit_out, 0);
    check("t1_err_cleared", err_credit, 0);
    tick(2);
    rst = 1'b1;
    tick();
    push_byte(8'hF1);
    send_cmd(4'h5, 4'd1, t);
    expect_flit(8'hF1, t + 2);
    wait_idle();
    tick(2);
    check("end_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
